// File: rtl/camera_fe_scheduler.sv
// Frame-level scheduler for the camera feature extractor:
// handshake, start pulse, watchdog, status and BatchNorm banks.
module camera_fe_scheduler #(
    parameter int CH      = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frm_valid,
    output logic              frm_ready,
    input  logic [TAG_W-1:0]  frm_tag,
    output logic              fe_start,
    input  logic              fe_done,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAG_W-1:0]  res_tag,
    output logic [1:0]        res_status,
    input  logic              cfg_we,
    input  logic [6:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    input  logic              cfg_commit,
    output logic              cfg_pending,
    output logic [CH*8-1:0]   bn_gamma,
    output logic [CH*8-1:0]   bn_beta,
    output logic [CH*8-1:0]   bn_mean,
    output logic [CH*8-1:0]   bn_var,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        timeout_cnt
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TO  = 2'b01;
    localparam logic [1:0] ST_AB  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_RESULT
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [TAG_W-1:0]     tag_q;
    logic [1:0]           status_q;
    logic [1:0]           status_nx;
    logic [CW-1:0]        wd_cnt;
    logic [3:0][CH*8-1:0] shadow;
    logic [3:0][CH*8-1:0] active;
    logic                 pend_q;

    logic accept;
    logic run_to;
    logic to_hit;
    logic res_hs;
    logic ch_ok;

    assign accept = (state == S_IDLE) && frm_valid;
    assign run_to = (wd_cnt == CW'(TIMEOUT - 1));
    assign to_hit = (state == S_RUN) && !fe_done && !abort && run_to;
    assign res_hs = (state == S_RESULT) && res_ready;
    assign ch_ok  = ({1'b0, cfg_addr[4:0]} < 6'(CH));

    always_comb begin
        state_nx  = state;
        status_nx = status_q;
        unique case (state)
            S_IDLE: begin
                if (frm_valid) state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                // Completion outranks abort, abort outranks the watchdog
                if (fe_done) begin
                    state_nx  = S_RESULT;
                    status_nx = ST_OK;
                end else if (abort) begin
                    state_nx  = S_RESULT;
                    status_nx = ST_AB;
                end else if (run_to) begin
                    state_nx  = S_RESULT;
                    status_nx = ST_TO;
                end
            end
            S_RESULT: begin
                if (res_ready) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state    <= state_nx;
            status_q <= status_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            wd_cnt      <= '0;
            frame_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (accept) tag_q <= frm_tag;
            if (state == S_LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (to_hit && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (res_hs && status_q == ST_OK) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Active banks only move on frame acceptance, from the pre-write shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pend_q <= 1'b0;
        end else begin
            if (accept && pend_q) active <= shadow;
            if (cfg_we && ch_ok) begin
                shadow[cfg_addr[6:5]][{cfg_addr[4:0], 3'b000} +: 8] <= cfg_wdata;
            end
            if (cfg_commit) begin
                pend_q <= 1'b1;
            end else if (accept) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign frm_ready   = (state == S_IDLE);
    assign fe_start    = (state == S_LAUNCH);
    assign res_valid   = (state == S_RESULT);
    assign busy        = (state != S_IDLE);
    assign res_tag     = tag_q;
    assign res_status  = status_q;
    assign cfg_pending = pend_q;
    assign bn_gamma    = active[0];
    assign bn_beta     = active[1];
    assign bn_mean     = active[2];
    assign bn_var      = active[3];

endmodule
